// File: rtl/pat_det_pkg.sv
// Shared types for the round-robin 101 detector scheduler.
// Scheduler/detector state enums plus the detector transition rule.
package pat_det_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    REPORT
  } sched_state_t;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  function automatic det_state_t det_next(
    input det_state_t s,
    input logic       b
  );
    det_state_t n;
    n = S0;
    case (s)
      S0: n = b ? S1 : S0;
      S1: n = b ? S1 : S2;
      S2: n = b ? S3 : S0;
      S3: n = b ? S1 : S2;
      default: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pat_det_sched_if.sv
// Requester-side bus of the 101 detector scheduler.
// master = requester side, slave = scheduler side.
interface pat_det_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDW   = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CNT_W-1:0]      match_cnt;

  modport master (
    output req, data,
    input  gnt, busy, done, done_id, match_cnt
  );

  modport slave (
    input  req, data,
    output gnt, busy, done, done_id, match_cnt
  );
endinterface

// File: rtl/pat101_core.sv
// Serial Moore detector for the bit pattern 101 (overlaps allowed).
// out is high while the detector sits in S3.
module pat101_core
  import pat_det_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       in,
  output logic       out,
  output det_state_t state_out
);

  det_state_t st;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= S0;
    end else if (clr) begin
      st <= S0;
    end else begin
      st <= det_next(st, in);
    end
  end

  assign out       = (st == S3);
  assign state_out = st;

endmodule

// File: rtl/pat_det_sched.sv
// Round-robin scheduler sharing one 101 detector among NREQ requesters.
// Grants, clears the detector, shifts the word MSB-first, reports hits.
module pat_det_sched
  import pat_det_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic            clock,
  input logic            reset,
  pat_det_sched_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDW   = $clog2(NREQ);
  localparam int BW    = $clog2(WIDTH);

  sched_state_t     state;
  sched_state_t     state_nx;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   cand;
  logic             found;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_fin;
  logic [CNT_W-1:0] rep_cnt;
  logic [IDW-1:0]   rep_id;
  logic             last_bit;
  logic             det_in;
  logic             det_out;
  det_state_t       det_st;

  pat101_core u_core (
    .clock     (clock),
    .reset     (reset),
    .clr       (state == LOAD),
    .in        (det_in),
    .out       (det_out),
    .state_out (det_st)
  );

  assign det_in   = (state == SHIFT) & shreg[WIDTH-1];
  assign last_bit = (bit_idx == BW'(WIDTH - 1));
  // out lags the fed bit by a cycle, so the last hit lands in REPORT
  assign cnt_fin  = cnt + CNT_W'(det_out);

  always_comb begin
    pick  = ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IDW'(k)) begin
        word = bus.data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (|bus.req) state_nx = LOAD;
      LOAD:   state_nx = SHIFT;
      SHIFT:  if (last_bit) state_nx = REPORT;
      REPORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr     <= '0;
      win     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      rep_id  <= '0;
      rep_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req) win <= pick;
        end
        LOAD: begin
          shreg   <= word;
          cnt     <= '0;
          bit_idx <= '0;
        end
        SHIFT: begin
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          bit_idx <= bit_idx + 1'b1;
          if (det_out) cnt <= cnt + 1'b1;
        end
        REPORT: begin
          rep_id  <= win;
          rep_cnt <= cnt_fin;
          ptr     <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state != IDLE);
    bus.gnt       = bus.busy ? (NREQ'(1) << win) : '0;
    bus.done      = (state == REPORT);
    bus.done_id   = bus.done ? win : rep_id;
    bus.match_cnt = bus.done ? cnt_fin : rep_cnt;
  end

endmodule

// File: tb/tb_pat_det_sched.sv
// Self-checking bench for pat_det_sched.
// Transaction-level reference model checked every cycle plus directed cases.
module tb_pat_det_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  pat_det_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  pat_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
  endtask

  function automatic int hits(logic [WIDTH-1:0] w);
    int h = 0;
    for (int i = WIDTH - 1; i >= 2; i--) begin
      if (w[i] && !w[i-1] && w[i-2]) h++;
    end
    return h;
  endfunction

  // detector state from the suffix of the first n bits fed MSB-first
  function automatic int det_ref(logic [WIDTH-1:0] w, int n);
    logic b0, b1, b2;
    b0 = (n >= 1) ? w[WIDTH-n]   : 1'b0;
    b1 = (n >= 2) ? w[WIDTH-n+1] : 1'b0;
    b2 = (n >= 3) ? w[WIDTH-n+2] : 1'b0;
    if (n >= 3 && b2 && !b1 && b0) return 3;
    if (n >= 1 && b0) return 1;
    if (n >= 2 && b1 && !b0) return 2;
    return 0;
  endfunction

  function automatic int rr_pick(int p, logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return p;
  endfunction

  int               m_age = -1;
  int               m_win = 0;
  int               m_ptr = 0;
  int               m_last_id = 0;
  int               m_last_cnt = 0;
  logic [WIDTH-1:0] m_word = '0;

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_id", bus.done_id, 0);
      chk("rst_cnt", bus.match_cnt, 0);
      m_age = -1;
      m_ptr = 0;
      m_last_id = 0;
      m_last_cnt = 0;
    end else begin
      chk("onehot", $onehot0(bus.gnt), 1);
      chk("busy", bus.busy, m_age >= 0);
      chk("gnt", bus.gnt, (m_age >= 0) ? (1 << m_win) : 0);
      chk("done", bus.done, m_age == WIDTH + 1);
      if (m_age == WIDTH + 1) begin
        m_last_id  = m_win;
        m_last_cnt = hits(m_word);
      end
      chk("done_id", bus.done_id, m_last_id);
      chk("match_cnt", bus.match_cnt, m_last_cnt);
      if (m_age >= 1) chk("det", dut.det_st, det_ref(m_word, m_age - 1));
      if (m_age < 0) begin
        if (|bus.req) begin
          m_win = rr_pick(m_ptr, bus.req);
          m_age = 0;
        end
      end else if (m_age == 0) begin
        m_word = bus.data[m_win*WIDTH +: WIDTH];
        m_age  = 1;
      end else if (m_age < WIDTH + 1) begin
        m_age++;
      end else begin
        m_ptr = (m_win + 1) % NREQ;
        m_age = -1;
      end
    end
  end

  task automatic drive(logic [NREQ-1:0] r);
    @(posedge clock);
    #2;
    bus.req = r;
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!bus.done && t < 60);
    if (!bus.done) chk("done_timeout", bus.done, 1);
  endtask

  task automatic wait_busy();
    int t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!bus.busy && t < 20);
    chk("busy_timeout", bus.busy, 1);
  endtask

  logic [WIDTH-1:0] words [4] = '{8'hAD, 8'hFF, 8'h05, 8'hAA};
  int               exp_h [4] = '{3, 0, 1, 3};
  int               rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    time t_prev;
    logic [WIDTH-1:0] w6;
    bus.req  = '0;
    bus.data = '0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      drive(4'b0001);
      bus.data[WIDTH-1:0] = words[i];
      wait_done();
      chk("dir_id", bus.done_id, 0);
      chk("dir_cnt", bus.match_cnt, exp_h[i]);
      drive(4'b0000);
    end

    drive(4'b0001);
    bus.data[WIDTH-1:0] = 8'(32'($urandom));
    wait_busy();
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    bus.req = '0;
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (14) @(negedge clock);

    drive(4'b1111);
    bus.data = 32'($urandom);
    t_prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_done();
      chk("rr_order", bus.done_id, rr_exp[i]);
      if (i > 0) chk("rr_period", 32'(($time - t_prev) / 10), WIDTH + 3);
      t_prev = $time;
    end
    drive(4'b0000);

    drive(4'b0010);
    wait_done();
    chk("wrap_pre", bus.done_id, 1);
    drive(4'b0011);
    wait_done();
    chk("wrap_0", bus.done_id, 0);
    wait_done();
    chk("wrap_1", bus.done_id, 1);
    drive(4'b0000);

    w6 = 8'b1101_0101;
    drive(4'b0100);
    bus.data[2*WIDTH +: WIDTH] = w6;
    wait_busy();
    repeat (4) @(negedge clock);
    drive(4'b0000);
    bus.data[2*WIDTH +: WIDTH] = ~w6;
    wait_done();
    chk("drop_id", bus.done_id, 2);
    chk("drop_cnt", bus.match_cnt, 3);

    repeat (600) begin
      @(posedge clock);
      #2;
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      if ($urandom_range(0, 1) == 0) bus.data = 32'($urandom);
    end
    bus.req = '0;
    repeat (15) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
